// File: rtl/proc_pkg.sv
// Shared types and constants for the memory port arbiter: FSM state encoding,
// port indices and default address/data widths.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 13;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: combinational winner selection between the fetch and data ports.
// On a tie the port that did not own the previous access wins.
module arb_pick
  import proc_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last_owner,
  output logic winner
);

  always_comb begin
    winner = PORT_DATA;
    if (f_req && d_req)
      winner = (last_owner == PORT_DATA) ? PORT_FETCH : PORT_DATA;
    else if (f_req)
      winner = PORT_FETCH;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port RAM with 1-cycle read latency.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed data-port priority.
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester holds req/we/addr/wdata stable until it sees its gnt,
  // which is high for exactly the one ACCESS cycle. For reads, rvalid is high for
  // exactly the following RESP cycle and qualifies rdata; rdata is otherwise stale.

  state_t            state;
  logic              owner;
  logic              winner;
  logic              pick_last;
  logic [DATA_W-1:0] f_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner;
  assign pick_last = last_owner;
`else
  // Presenting fetch as the previous owner makes every tie resolve to the data port.
  assign pick_last = PORT_FETCH;
`endif

  arb_pick u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_owner (pick_last),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= PORT_FETCH;
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner <= PORT_DATA;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            state     <= ACCESS;
            owner     <= winner;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= (winner == PORT_DATA) ? d_we    : f_we;
            mem_addr  <= (winner == PORT_DATA) ? d_addr  : f_addr;
            mem_wdata <= (winner == PORT_DATA) ? d_wdata : f_wdata;
            f_gnt     <= (winner == PORT_FETCH);
            d_gnt     <= (winner == PORT_DATA);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner <= winner;
`endif
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          f_gnt  <= 1'b0;
          d_gnt  <= 1'b0;
          // mem_we still carries the owner's command during this cycle.
          if (mem_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= RESP;
            f_rvalid <= (owner == PORT_FETCH);
            d_rvalid <= (owner == PORT_DATA);
          end
        end
        RESP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          f_rvalid <= 1'b0;
          d_rvalid <= 1'b0;
          if (f_rvalid) f_rdata_q <= mem_rdata;
          if (d_rvalid) d_rdata_q <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // mem_rdata is the RAM's own output register, so RESP forwards it directly and
  // the local copy keeps the value stable afterwards.
  assign f_rdata   = f_rvalid ? mem_rdata : f_rdata_q;
  assign d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural 1-cycle RAM and a
// scoreboard of expected grants and read data. Honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, f_we, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] f_wdata, d_wdata;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] f_rdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    state_dbg;

  logic [DW-1:0] ram [512];
  logic [DW-1:0] mdl [512];
  logic [DW-1:0] f_exp_q [$];
  logic [DW-1:0] d_exp_q [$];
  logic          gnt_exp_q [$];
  logic          mdl_last;
  int            n_cmp = 0;
  int            n_err = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // behavioural single-port RAM, read data one cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard model
  function automatic logic model_pick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return (mdl_last == 1'b1) ? 1'b0 : 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic expect_access(input logic port, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    gnt_exp_q.push_back(port);
    if (we) mdl[addr] = wdata;
    else if (port) d_exp_q.push_back(mdl[addr]);
    else f_exp_q.push_back(mdl[addr]);
    mdl_last = port;
  endtask

  always @(negedge clk) begin
    if (f_gnt || d_gnt) begin
      chk("one_gnt", 32'(f_gnt & d_gnt), 0);
      chk("gnt_mem_en", 32'(mem_en), 1);
      if (gnt_exp_q.size() == 0) chk("unexp_gnt", 32'(d_gnt), 32'(!d_gnt));
      else chk("gnt_port", 32'(d_gnt), 32'(gnt_exp_q.pop_front()));
    end else if (mem_en) begin
      chk("mem_en_no_gnt", 32'(mem_en), 0);
    end
    if (mem_we && !mem_en) chk("we_without_en", 32'(mem_we), 0);
    if (f_rvalid && d_rvalid) chk("both_rvalid", 32'(d_rvalid), 0);
    if (f_rvalid) begin
      if (f_exp_q.size() == 0) chk("unexp_f_rvalid", 32'(f_rvalid), 0);
      else chk("f_rdata", 32'(f_rdata), 32'(f_exp_q.pop_front()));
    end
    if (d_rvalid) begin
      if (d_exp_q.size() == 0) chk("unexp_d_rvalid", 32'(d_rvalid), 0);
      else chk("d_rdata", 32'(d_rdata), 32'(d_exp_q.pop_front()));
    end
  end

  // driver tasks (all called right after a falling edge)
  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en, mem_we, busy, state_dbg}), 0);
    chk({tag, "_f_rdata"}, 32'(f_rdata), 0);
    chk({tag, "_d_rdata"}, 32'(d_rdata), 0);
    chk({tag, "_mem_cmd"}, 32'({mem_addr, mem_wdata}), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    f_req = 1'b0; f_we = 1'b0; f_addr = '0; f_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    mdl_last = 1'b1;
  endtask

  task automatic port_access(input logic port, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, output int lat);
    logic got = 1'b0;
    if (port) begin d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1; end
    else      begin f_we = we; f_addr = addr; f_wdata = wdata; f_req = 1'b1; end
    lat = 0;
    while (!got && lat < 30) begin
      @(negedge clk);
      lat++;
      got = port ? d_gnt : f_gnt;
    end
    if (!got) chk("gnt_timeout", 0, 1);
    if (port) begin d_req = 1'b0; d_we = 1'b0; end
    else      begin f_req = 1'b0; f_we = 1'b0; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    int lat, lat_f, lat_d;
    logic w;
    logic          pw [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];

    for (int i = 0; i < 512; i++) begin
      ram[i] = DW'($urandom_range(0, 8191));
      mdl[i] = ram[i];
    end
    ram[5] = 13'h1ABC; mdl[5] = 13'h1ABC;
    mem_rdata = '0;
    @(negedge clk);
    do_reset();

    // fetch read timing and rdata hold
    f_addr = 9'h005; f_we = 1'b0; f_req = 1'b1;
    expect_access(1'b0, 1'b0, 9'h005, '0);
    @(negedge clk);
    chk("rd_f_gnt", 32'(f_gnt), 1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h005);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_state_access", 32'(state_dbg), 1);
    f_req = 1'b0;
    @(negedge clk);
    chk("rd_f_rvalid", 32'(f_rvalid), 1);
    chk("rd_f_rdata", 32'(f_rdata), 32'h1ABC);
    chk("rd_d_rvalid", 32'(d_rvalid), 0);
    chk("rd_busy_resp", 32'(busy), 1);
    @(negedge clk);
    chk("rd_busy_done", 32'(busy), 0);
    chk("rd_f_rvalid_done", 32'(f_rvalid), 0);
    chk("rd_f_rdata_hold", 32'(f_rdata), 32'h1ABC);
    chk("rd_d_rdata_untouched", 32'(d_rdata), 0);

    // data write to the top address
    d_addr = 9'h1FF; d_wdata = 13'h0F0F; d_we = 1'b1; d_req = 1'b1;
    expect_access(1'b1, 1'b1, 9'h1FF, 13'h0F0F);
    @(negedge clk);
    chk("wr_d_gnt", 32'(d_gnt), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h1FF);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h0F0F);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("wr_idle", 32'(state_dbg), 0);
    chk("wr_busy", 32'(busy), 0);
    chk("wr_no_rvalid", 32'(d_rvalid), 0);
    chk("wr_ram", 32'(ram[9'h1FF]), 32'h0F0F);
    expect_access(1'b1, 1'b0, 9'h1FF, '0);
    port_access(1'b1, 1'b0, 9'h1FF, '0, lat);
    chk("wr_rb_lat", lat, 1);
    wait_idle();
    chk("f_rdata_hold_after_d", 32'(f_rdata), 32'h1ABC);

    // both ports reading continuously for 12 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = model_pick();
      expect_access(w, 1'b0, w ? 9'h020 : 9'h010, '0);
    end
    f_addr = 9'h010; d_addr = 9'h020; f_we = 1'b0; d_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    repeat (12) @(negedge clk);
    f_req = 1'b0; d_req = 1'b0;
    wait_idle();
    chk("arb_gnt_left", gnt_exp_q.size(), 0);
    chk("arb_f_left", f_exp_q.size(), 0);
    chk("arb_d_left", d_exp_q.size(), 0);

    // reset during the ACCESS cycle of a read
    do_reset();
    f_addr = 9'h007; f_we = 1'b0; f_req = 1'b1;
    gnt_exp_q.push_back(1'b0);
    @(negedge clk);
    chk("rst_acc_f_gnt", 32'(f_gnt), 1);
    f_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_zero("rst_acc");
    reset = 1'b0;
    mdl_last = 1'b1;
    repeat (3) @(negedge clk);
    expect_access(1'b0, 1'b0, 9'h007, '0);
    port_access(1'b0, 1'b0, 9'h007, '0, lat);
    chk("rst_acc_next_lat", lat, 1);
    wait_idle();

    // data request arriving while a fetch read is in flight
    expect_access(1'b0, 1'b0, 9'h033, '0);
    expect_access(1'b1, 1'b0, 9'h044, '0);
    f_addr = 9'h033; f_req = 1'b1;
    @(negedge clk);
    chk("busy_f_gnt", 32'(f_gnt), 1);
    f_req = 1'b0;
    d_addr = 9'h044; d_we = 1'b0; d_req = 1'b1;
    lat = 0;
    while (d_gnt !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_d_lat", lat, 3);
    d_req = 1'b0;
    wait_idle();

    // random traffic, single and simultaneous requests
    for (int it = 0; it < 24; it++) begin
      int mode = $urandom_range(0, 2);
      for (int p = 0; p < 2; p++) begin
        pw[p] = 1'($urandom_range(0, 1));
        pa[p] = AW'($urandom_range(0, 15));
        pd[p] = DW'($urandom_range(0, 8191));
      end
      if (mode < 2) begin
        expect_access(1'(mode), pw[mode], pa[mode], pd[mode]);
        port_access(1'(mode), pw[mode], pa[mode], pd[mode], lat);
        chk("rnd_single_lat", lat, 1);
      end else begin
        w = model_pick();
        expect_access(w, pw[w], pa[w], pd[w]);
        expect_access(!w, pw[!w], pa[!w], pd[!w]);
        fork
          port_access(1'b0, pw[0], pa[0], pd[0], lat_f);
          port_access(1'b1, pw[1], pa[1], pd[1], lat_d);
        join
        chk("rnd_pair_first", (w ? lat_d : lat_f), 1);
      end
      wait_idle();
    end

    chk("end_gnt_left", gnt_exp_q.size(), 0);
    chk("end_f_left", f_exp_q.size(), 0);
    chk("end_d_left", d_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
